fetch_unit: RTL and testbench

//   Instruction fetch stage: the producer side of the decode stage's instruction input.

---
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-outstanding memory reads, instruction FIFO to decode
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [XLEN-1:0]                 mem_req_addr,
  input  logic                            mem_rsp_valid,
  input  logic [31:0]                     mem_rsp_data,
  input  logic                            mem_rsp_err,
  input  logic                            redirect_valid,
  input  logic [XLEN-1:0]                 redirect_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [31:0]                     instr_data,
  output logic [XLEN-1:0]                 instr_pc,
  output logic                            instr_fault,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d, base;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic            valid_q;
  logic [31:0]     data_mem  [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic            fault_mem [FIFO_DEPTH];

  logic            hs, rsp_ok, pop, push, push_fault, flush;
  logic [31:0]     push_data;
  logic [XLEN-1:0] push_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign hs     = req_valid_q & mem_req_ready;
  assign rsp_ok = mem_rsp_valid & inflight_q;
  assign pop    = valid_q & instr_ready;
  assign base   = count_q - CW'(pop);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;
    push        = 1'b0;
    push_data   = '0;
    push_pc     = req_addr_q;
    push_fault  = 1'b0;
    flush       = 1'b0;

    // A redirected request keeps pc at the redirect target when it finally handshakes
    if (hs) begin
      req_valid_d = 1'b0;
      inflight_d  = 1'b1;
      if (!drop_q) pc_d = pc_q + XLEN'(4);
    end
    if (rsp_ok) inflight_d = 1'b0;

    if (redirect_valid) begin
      flush  = 1'b1;
      pc_d   = redirect_pc;
      drop_d = req_valid_q | (inflight_q & ~mem_rsp_valid);
      if (redirect_pc[1:0] != 2'b00) begin
        push       = 1'b1;
        push_pc    = redirect_pc;
        push_fault = 1'b1;
        state_d    = S_HALT;
      end else if (req_valid_q && !mem_req_ready) begin
        state_d = S_REQ;
      end else if (drop_d) begin
        state_d = S_DROP;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (base < DEPTH_C) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = pc_q;
          end
        end
        S_REQ: begin
          if (hs) state_d = drop_q ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (rsp_ok) begin
            push       = 1'b1;
            push_data  = mem_rsp_err ? 32'h0 : mem_rsp_data;
            push_fault = mem_rsp_err;
            if (mem_rsp_err) begin
              state_d = S_HALT;
            end else if ((base + CW'(1)) < DEPTH_C) begin
              state_d     = S_REQ;
              req_valid_d = 1'b1;
              req_addr_d  = pc_q;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (rsp_ok) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_HALT: begin
          if (rsp_ok) drop_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    count_d = flush ? CW'(push) : (count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i]  <= '0;
        pc_mem[i]    <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      valid_q     <= (count_d != '0);
      if (flush) begin
        // Flush beats any coincident pop; a misaligned-redirect fault lands in slot 0
        rd_ptr_q <= '0;
        wr_ptr_q <= push ? ptr_inc('0) : '0;
        if (push) begin
          data_mem[0]  <= push_data;
          pc_mem[0]    <= push_pc;
          fault_mem[0] <= push_fault;
        end
      end else begin
        if (push) begin
          data_mem[wr_ptr_q]  <= push_data;
          pc_mem[wr_ptr_q]    <= push_pc;
          fault_mem[wr_ptr_q] <= push_fault;
          wr_ptr_q            <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_rsp_valid && !inflight_q)
      $error("fetch_unit: response with no request outstanding");
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign instr_valid   = valid_q;
  assign instr_data    = data_mem[rd_ptr_q];
  assign instr_pc      = pc_mem[rd_ptr_q];
  assign instr_fault   = fault_mem[rd_ptr_q];
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = 32'h0;
  logic        mem_rsp_err   = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic [1:0]  fifo_count;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault),
    .fifo_count     (fifo_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] issued[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        got_fault[$];
  int          rsp_delay = 0;
  int          rsp_cnt   = 0;
  logic [31:0] rsp_addr  = 32'h0;
  logic        err_en    = 1'b0;
  logic [31:0] err_addr  = 32'h0;

  // Memory model (word = ~addr) and decode-side log, all driven/sampled on the falling edge
  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_data  = 32'h0;
    if (!rst_n) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = ~rsp_addr;
          mem_rsp_err   = err_en && (rsp_addr == err_addr);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        issued.push_back(mem_req_addr);
        rsp_addr = mem_req_addr;
        rsp_cnt  = rsp_delay + 1;
      end
      if (instr_valid && instr_ready) begin
        got_pc.push_back(instr_pc);
        got_data.push_back(instr_data);
        got_fault.push_back(instr_fault);
      end
    end
  end

  task automatic wait_got(input string tag, input int n);
    int b = 0;
    while (got_pc.size() < n && b < 200) begin
      @(negedge clk);
      b++;
    end
    check_eq(tag, 64'(got_pc.size() >= n), 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    got_pc.delete();
    got_data.delete();
    got_fault.delete();
  endtask

  task automatic wait_req(input string tag, input bit need_hs, input int need_cnt);
    bit found = 0;
    for (int b = 0; b < 100 && !found; b++) begin
      @(negedge clk);
      if (mem_req_valid && (!need_hs || mem_req_ready) && (need_cnt < 0 || fifo_count == need_cnt))
        found = 1;
    end
    check_eq(tag, 64'(found), 64'd1);
  endtask

  int          ib;
  logic [31:0] exp_a;

  initial begin
    rst_n          = 1'b0;
    mem_req_ready  = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", mem_req_valid, 0);
    check_eq("rst_req_addr", mem_req_addr, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_instr_pc", instr_pc, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("req_before_first_edge", mem_req_valid, 0);
    @(negedge clk);
    check_eq("req_after_first_edge", mem_req_valid, 1);
    check_eq("first_req_addr", mem_req_addr, 32'h0);

    // Decode stalled: two words buffered, fetch stops
    repeat (20) @(negedge clk);
    check_eq("stall_fifo_count", fifo_count, 2);
    check_eq("stall_req_valid", mem_req_valid, 0);
    check_eq("stall_issued", issued.size(), 2);
    check_eq("stall_issued1", issued[1], 32'h4);

    @(posedge clk); #1 instr_ready = 1'b1;
    wait_got("a_got3", 3);
    check_eq("a_pc0", got_pc[0], 32'h0);
    check_eq("a_pc1", got_pc[1], 32'h4);
    check_eq("a_pc2", got_pc[2], 32'h8);
    check_eq("a_data0", got_data[0], 32'hFFFF_FFFF);
    check_eq("a_data1", got_data[1], 32'hFFFF_FFFB);
    check_eq("a_data2", got_data[2], 32'hFFFF_FFF7);
    check_eq("a_fault2", got_fault[2], 0);
    check_eq("a_resume_addr", issued[2], 32'h8);

    // Redirect while waiting on a slow response with one word buffered
    @(posedge clk); #1;
    instr_ready = 1'b0;
    rsp_delay   = 3;
    wait_req("b_find_wait", 1, 1);
    do_redirect(32'h100);
    ib = issued.size();
    @(negedge clk);
    check_eq("b_flush_count", fifo_count, 0);
    check_eq("b_flush_valid", instr_valid, 0);
    rsp_delay   = 0;
    instr_ready = 1'b1;
    wait_got("b_got", 1);
    check_eq("b_pc", got_pc[0], 32'h100);
    check_eq("b_data", got_data[0], 32'hFFFF_FEFF);
    check_eq("b_next_req", issued[ib], 32'h100);

    // Redirect while a request is held by a stalled memory
    @(posedge clk); #1 mem_req_ready = 1'b0;
    wait_req("c_find_req", 0, -1);
    exp_a = issued[issued.size()-1] + 32'h4;
    ib    = issued.size();
    do_redirect(32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("c_hold_valid", mem_req_valid, 1);
      check_eq("c_hold_addr", mem_req_addr, exp_a);
    end
    @(posedge clk); #1 mem_req_ready = 1'b1;
    wait_got("c_got", 1);
    check_eq("c_pc", got_pc[0], 32'h200);
    check_eq("c_data", got_data[0], 32'hFFFF_FDFF);
    check_eq("c_old_req", issued[ib], exp_a);
    check_eq("c_new_req", issued[ib+1], 32'h200);

    // Access fault at 0x8 halts fetch
    err_addr = 32'h8;
    err_en   = 1'b1;
    do_redirect(32'h0);
    wait_got("d_got3", 3);
    check_eq("d_pc1", got_pc[1], 32'h4);
    check_eq("d_fault1", got_fault[1], 0);
    check_eq("d_pc2", got_pc[2], 32'h8);
    check_eq("d_fault2", got_fault[2], 1);
    repeat (10) @(negedge clk);
    check_eq("d_halt_req", mem_req_valid, 0);
    check_eq("d_halt_last_req", issued[issued.size()-1], 32'h8);
    check_eq("d_halt_count", got_pc.size(), 3);
    err_en = 1'b0;
    do_redirect(32'h40);
    wait_got("d_resume", 1);
    check_eq("d_resume_pc", got_pc[0], 32'h40);
    check_eq("d_resume_fault", got_fault[0], 0);

    // Misaligned redirect yields a fault entry without a memory access
    do_redirect(32'h102);
    ib = issued.size();
    repeat (10) @(negedge clk);
    check_eq("e_got_count", got_pc.size(), 1);
    check_eq("e_pc", got_pc[0], 32'h102);
    check_eq("e_fault", got_fault[0], 1);
    check_eq("e_data", got_data[0], 32'h0);
    check_eq("e_no_req", issued.size(), ib);
    check_eq("e_req_valid", mem_req_valid, 0);

    // Asynchronous reset in the middle of a wait
    rsp_delay = 3;
    do_redirect(32'h40);
    wait_req("f_find_hs", 1, -1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("f_rst_req_valid", mem_req_valid, 0);
    check_eq("f_rst_req_addr", mem_req_addr, 0);
    check_eq("f_rst_instr_valid", instr_valid, 0);
    check_eq("f_rst_count", fifo_count, 0);
    check_eq("f_rst_instr_pc", instr_pc, 0);
    check_eq("f_rst_instr_fault", instr_fault, 0);
    repeat (2) @(negedge clk);
    rsp_delay = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_pc.delete();
    got_data.delete();
    got_fault.delete();
    ib = issued.size();
    wait_got("f_got", 1);
    check_eq("f_pc", got_pc[0], 32'h0);
    check_eq("f_data", got_data[0], 32'hFFFF_FFFF);
    check_eq("f_first_req", issued[ib], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
